// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Accepts one ALU request at a time, screens it for illegal op
//            codes and divide/mod by zero, drives legal requests to an
//            external combinational ALU for one cycle, captures the result
//            and holds it as a response until it is consumed.
// Ports    : clk_i, rst_i                 clock, async active-high reset
//            req_valid_i/req_ready_o      request handshake
//            req_op_i, req_a_i, req_b_i   op code and operands
//            alu_ctrl_o, alu_data0_o/1_o  registered drive to the ALU
//            alu_result_i                 combinational ALU result
//            rsp_valid_o/rsp_ready_i      response handshake
//            rsp_result_o, rsp_err_o      captured result and error code
//            op_count_o                   completed response handshakes
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_op_i,
    input  logic [7:0]         req_a_i,
    input  logic [7:0]         req_b_i,
    output logic [2:0]         alu_ctrl_o,
    output logic [7:0]         alu_data0_o,
    output logic [7:0]         alu_data1_o,
    input  logic [7:0]         alu_result_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [7:0]         rsp_result_o,
    output logic [1:0]         rsp_err_o,
    output logic [COUNT_W-1:0] op_count_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_MOD = 3'b100;

    localparam logic [1:0] c_ERR_OK   = 2'b00;
    localparam logic [1:0] c_ERR_ILL  = 2'b01;
    localparam logic [1:0] c_ERR_DIVZ = 2'b10;

    localparam logic [COUNT_W-1:0] c_CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_req_ready;
    logic               w_rsp_valid;
    logic               w_accept;
    logic               w_rsp_done;
    logic               w_illegal;
    logic               w_div_zero;

    logic [2:0]         r_alu_ctrl;
    logic [7:0]         r_alu_data0;
    logic [7:0]         r_alu_data1;
    logic [7:0]         r_rsp_result;
    logic [1:0]         r_rsp_err;
    logic [COUNT_W-1:0] r_op_count;

    assign w_accept   = req_valid_i & w_req_ready;
    assign w_rsp_done = w_rsp_valid & rsp_ready_i;

    // Ops 101..111 are undefined; only div and mod can trap on a zero divisor.
    assign w_illegal  = (req_op_i > c_OP_MOD);
    assign w_div_zero = ((req_op_i == c_OP_DIV) || (req_op_i == c_OP_MOD)) &&
                        (req_b_i == 8'h00);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; errored requests skip ISSUE and respond one cycle early.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_illegal || w_div_zero) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_RESP;
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_req_ready = 1'b1;
            S_RESP:  w_rsp_valid = 1'b1;
            default: begin
                w_req_ready = 1'b0;
                w_rsp_valid = 1'b0;
            end
        endcase
    end

    // ALU drive is latched on accept and held until the next accept, so the
    // ALU output is settled by the time ISSUE closes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alu_ctrl  <= 3'b000;
            r_alu_data0 <= 8'h00;
            r_alu_data1 <= 8'h00;
        end else if (w_accept) begin
            r_alu_ctrl  <= req_op_i;
            r_alu_data0 <= req_a_i;
            r_alu_data1 <= req_b_i;
        end
    end

    // Response capture; values persist after the handshake until overwritten.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_result <= 8'h00;
            r_rsp_err    <= c_ERR_OK;
        end else if (w_accept && w_illegal) begin
            r_rsp_result <= 8'h00;
            r_rsp_err    <= c_ERR_ILL;
        end else if (w_accept && w_div_zero) begin
            r_rsp_result <= 8'h00;
            r_rsp_err    <= c_ERR_DIVZ;
        end else if (r_state == S_ISSUE) begin
            r_rsp_result <= alu_result_i;
            r_rsp_err    <= c_ERR_OK;
        end
    end

    // Completed-operation counter, wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op_count <= '0;
        end else if (w_rsp_done) begin
            r_op_count <= r_op_count + c_CNT_ONE;
        end
    end

    assign req_ready_o  = w_req_ready;
    assign rsp_valid_o  = w_rsp_valid;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign alu_data0_o  = r_alu_data0;
    assign alu_data1_o  = r_alu_data1;
    assign rsp_result_o = r_rsp_result;
    assign rsp_err_o    = r_rsp_err;
    assign op_count_o   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer wired to a behavioural
//            ALU; directed cases, backpressure, reset mid-response and a
//            randomized run against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int COUNT_W = 8;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [7:0]         req_a;
    logic [7:0]         req_b;
    logic [2:0]         alu_ctrl;
    logic [7:0]         alu_data0;
    logic [7:0]         alu_data1;
    logic [7:0]         alu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_result;
    logic [1:0]         rsp_err;
    logic [COUNT_W-1:0] op_count;

    int n_total;
    int n_bad;
    int exp_cnt;

    alu_sequencer #(.COUNT_W(COUNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_data0_o  (alu_data0),
        .alu_data1_o  (alu_data1),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_err_o    (rsp_err),
        .op_count_o   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team ALU: combinational, 8-bit wrap, zero on divide by zero.
    always_comb begin
        alu_result = 8'h00;
        case (alu_ctrl)
            3'd0: alu_result = alu_data0 + alu_data1;
            3'd1: alu_result = alu_data0 - alu_data1;
            3'd2: alu_result = alu_data0 * alu_data1;
            3'd3: alu_result = (alu_data1 == 8'h00) ? 8'h00 : alu_data0 / alu_data1;
            3'd4: alu_result = (alu_data1 == 8'h00) ? 8'h00 : alu_data0 % alu_data1;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the response should be, from the op definitions.
    task automatic ref_op(input int op, input int a, input int b,
                          output int r, output int e);
        r = 0;
        e = 0;
        if (op > 4) begin
            e = 1;
        end else if ((op == 3 || op == 4) && b == 0) begin
            e = 2;
        end else begin
            case (op)
                0: r = (a + b) % 256;
                1: r = (a - b + 256) % 256;
                2: r = (a * b) % 256;
                3: r = a / b;
                default: r = a % b;
            endcase
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_alu_ctrl"},  32'(alu_ctrl),  32'd0);
        chk({pfx, "_alu_data0"}, 32'(alu_data0), 32'd0);
        chk({pfx, "_alu_data1"}, 32'(alu_data1), 32'd0);
        chk({pfx, "_rsp_result"},32'(rsp_result),32'd0);
        chk({pfx, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({pfx, "_op_count"},  32'(op_count),  32'd0);
    endtask

    // Called at a negedge with the DUT idle. Runs one full transaction,
    // holding rsp_ready low for 'stall' cycles while spamming req_valid.
    task automatic do_op(input int op, input int a, input int b, input int stall);
        int er;
        int ee;
        ref_op(op, a, b, er, ee);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_a     = 8'(a);
        req_b     = 8'(b);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        chk("alu_ctrl",  32'(alu_ctrl),  32'(op));
        chk("alu_data0", 32'(alu_data0), 32'(a));
        chk("alu_data1", 32'(alu_data1), 32'(b));
        chk("busy_ready", 32'(req_ready), 32'd0);
        if (ee == 0) begin
            chk("issue_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("rsp_valid",  32'(rsp_valid),  32'd1);
        chk("rsp_result", 32'(rsp_result), 32'(er));
        chk("rsp_err",    32'(rsp_err),    32'(ee));
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid",  32'(rsp_valid),  32'd1);
            chk("stall_result", 32'(rsp_result), 32'(er));
            chk("stall_err",    32'(rsp_err),    32'(ee));
            chk("stall_ready",  32'(req_ready),  32'd0);
            chk("stall_ctrl",   32'(alu_ctrl),   32'(op));
            chk("stall_data0",  32'(alu_data0),  32'(a));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("done_valid",  32'(rsp_valid),  32'd0);
        chk("done_ready",  32'(req_ready),  32'd1);
        chk("op_count",    32'(op_count),   32'(exp_cnt % 256));
        chk("keep_result", 32'(rsp_result), 32'(er));
        chk("keep_err",    32'(rsp_err),    32'(ee));
    endtask

    initial begin
        int op;
        int a;
        int b;
        n_total   = 0;
        n_bad     = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;

        // Directed cases; first accept lands on the first edge after reset.
        do_op(0, 200, 100, 0);
        do_op(1, 5, 10, 0);
        do_op(3, 100, 7, 0);
        do_op(4, 100, 7, 0);
        do_op(3, 9, 0, 0);
        do_op(5, 1, 2, 0);
        do_op(7, 8'hFF, 8'hFF, 1);
        do_op(4, 50, 0, 2);
        do_op(2, 16, 17, 0);
        do_op(0, 255, 1, 0);

        // Backpressure: five held cycles, handshake on the sixth.
        do_op(2, 13, 11, 5);

        // Reset while the response is pending.
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 8'd3;
        req_b     = 8'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;

        // Reset while in ISSUE discards the op.
        req_valid = 1'b1;
        req_op    = 3'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1 chk_reset_vals("issue_rst");
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b0;

        // Randomized run of exactly 256 ops: count must come back to zero.
        for (int n = 0; n < 256; n++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op(op, a, b, int'($urandom_range(0, 2)));
        end
        chk("count_wrap", 32'(op_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
